// File: rtl/audio_route_sequencer_if.sv
// Routing request/status bundle between the effect-routing controller and the
// audio_route_sequencer; source vectors are 3-bit codes per stage.
interface audio_route_sequencer_if;
  logic [2:0]  output_src_req;
  logic [2:0]  delay_src_req;
  logic [2:0]  distortion_src_req;
  logic [2:0]  crush_src_req;
  logic [2:0]  filter_src_req;
  logic [2:0]  reverb_src_req;
  logic        sample_tick;

  logic [2:0]  output_src_on_clk;
  logic [2:0]  delay_src_on_clk;
  logic [2:0]  distortion_src_on_clk;
  logic [2:0]  crush_src_on_clk;
  logic [2:0]  filter_src_on_clk;
  logic [2:0]  reverb_src_on_clk;
  logic [10:0] fade_gain;
  logic        busy;
  logic        cfg_error;

  modport master (
    output output_src_req, delay_src_req, distortion_src_req,
           crush_src_req, filter_src_req, reverb_src_req, sample_tick,
    input  output_src_on_clk, delay_src_on_clk, distortion_src_on_clk,
           crush_src_on_clk, filter_src_on_clk, reverb_src_on_clk,
           fade_gain, busy, cfg_error
  );

  modport slave (
    input  output_src_req, delay_src_req, distortion_src_req,
           crush_src_req, filter_src_req, reverb_src_req, sample_tick,
    output output_src_on_clk, delay_src_on_clk, distortion_src_on_clk,
           crush_src_on_clk, filter_src_on_clk, reverb_src_on_clk,
           fade_gain, busy, cfg_error
  );
endinterface

// File: rtl/audio_route_sequencer.sv
// Click-free audio routing swap: fade out, swap all stage sources at once, settle, fade in.
// Define ROUTE_LOOP_CHECK_EN to add a CHECK state that rejects routing loops.
module audio_route_sequencer #(
  parameter int FADE_LOG2    = 6,
  parameter int SETTLE_TICKS = 4   // minimum 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  audio_route_sequencer_if.slave  rt
);

  localparam logic [10:0] UNITY    = 11'd1024;
  localparam logic [10:0] STEP     = 11'(1024 >> FADE_LOG2);
  localparam int          SETTLE_W = (SETTLE_TICKS > 2) ? $clog2(SETTLE_TICKS) : 1;
  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_TICKS - 1);

`ifdef ROUTE_LOOP_CHECK_EN
  localparam logic [2:0] MAX_HOPS = 3'd6;
  typedef enum logic [2:0] {IDLE, CHECK, FADE_OUT, SETTLE, FADE_IN} state_e;
`else
  typedef enum logic [2:0] {IDLE, FADE_OUT, SETTLE, FADE_IN} state_e;
`endif

  // Index 0 is the output stage; index k (1..5) is the stage selected by source code k.
  typedef logic [5:0][2:0] route_t;

  state_e                state_q;
  route_t                active_q;
  route_t                cand_q;
  route_t                rejected_q;
  logic [10:0]           gain_q;
  logic [SETTLE_W-1:0]   settle_q;
  logic                  busy_q;
  logic                  cfg_error_q;

  route_t                req_vec;
  logic                  req_illegal;
  logic                  req_new;
  logic [10:0]           gain_dn;
  logic [10:0]           gain_up;
  logic                  tick;

  assign tick    = rt.sample_tick;
  assign req_vec = {rt.reverb_src_req, rt.filter_src_req, rt.crush_src_req,
                    rt.distortion_src_req, rt.delay_src_req, rt.output_src_req};
  assign req_new = (req_vec != active_q) && (req_vec != rejected_q);

  // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    req_illegal = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (req_vec[i] > 3'd5) req_illegal = 1'b1;
      if (i != 0 && req_vec[i] == 3'(i)) req_illegal = 1'b1;
    end
  end

  assign gain_dn = (gain_q > STEP)         ? gain_q - STEP : 11'd0;
  assign gain_up = (gain_q < UNITY - STEP) ? gain_q + STEP : UNITY;

`ifdef ROUTE_LOOP_CHECK_EN
  logic [2:0] walk_q;
  logic [2:0] hops_q;
  logic [2:0] hop_src;

  always_comb begin
    hop_src = 3'd0;
    for (int i = 1; i < 6; i++) begin
      if (walk_q == 3'(i)) hop_src = cand_q[i];
    end
  end
`endif

  // NOTE: sequential state uses non-blocking assignments only; every register here is
  // plain flop state (no memory array), so all of it is cleared by the async reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      active_q    <= '0;
      cand_q      <= '0;
      rejected_q  <= '0;
      gain_q      <= UNITY;
      settle_q    <= '0;
      busy_q      <= 1'b0;
      cfg_error_q <= 1'b0;
`ifdef ROUTE_LOOP_CHECK_EN
      walk_q      <= '0;
      hops_q      <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (req_new) begin
            if (req_illegal) begin
              rejected_q  <= req_vec;
              cfg_error_q <= 1'b1;
            end else begin
              cand_q <= req_vec;
              busy_q <= 1'b1;
`ifdef ROUTE_LOOP_CHECK_EN
              state_q <= CHECK;
              walk_q  <= req_vec[0];
              hops_q  <= '0;
`else
              state_q <= FADE_OUT;
              if (tick) gain_q <= gain_dn;
`endif
            end
          end
        end

`ifdef ROUTE_LOOP_CHECK_EN
        CHECK: begin
          if (walk_q == 3'd0) begin
            state_q <= FADE_OUT;
            if (tick) gain_q <= gain_dn;
          end else if (hops_q == MAX_HOPS) begin
            // Still not at the base source after six hops: the chain loops.
            rejected_q  <= cand_q;
            cfg_error_q <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end else begin
            walk_q <= hop_src;
            hops_q <= hops_q + 3'd1;
          end
        end
`endif

        FADE_OUT: begin
          if (tick) begin
            gain_q <= gain_dn;
            if (gain_dn == 11'd0) begin
              active_q <= cand_q;
              settle_q <= '0;
              state_q  <= SETTLE;
            end
          end
        end

        SETTLE: begin
          if (tick) begin
            if (settle_q == SETTLE_LAST) state_q  <= FADE_IN;
            else                         settle_q <= settle_q + 1'b1;
          end
        end

        FADE_IN: begin
          if (tick) begin
            gain_q <= gain_up;
            if (gain_up == UNITY) begin
              state_q     <= IDLE;
              busy_q      <= 1'b0;
              cfg_error_q <= 1'b0;
            end
          end
        end

        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign rt.output_src_on_clk     = active_q[0];
  assign rt.delay_src_on_clk      = active_q[1];
  assign rt.distortion_src_on_clk = active_q[2];
  assign rt.crush_src_on_clk      = active_q[3];
  assign rt.filter_src_on_clk     = active_q[4];
  assign rt.reverb_src_on_clk     = active_q[5];
  assign rt.fade_gain             = gain_q;
  assign rt.busy                  = busy_q;
  assign rt.cfg_error             = cfg_error_q;

  a_gain_range: assert property (@(posedge clk) disable iff (!rst_n) gain_q <= UNITY);
  a_busy_state: assert property (@(posedge clk) disable iff (!rst_n)
                                 busy_q == (state_q != IDLE));
  a_swap_only_on_settle: assert property (@(posedge clk) disable iff (!rst_n)
                                 (active_q != $past(active_q)) |-> (state_q == SETTLE));

endmodule

// File: tb/tb_audio_route_sequencer.sv
// Directed bench for audio_route_sequencer; expectations are hand-derived gain ramps
// and routing vectors (step 16, 64 ticks per fade, 4 settle ticks).
module tb_audio_route_sequencer;

  localparam int FADE_LOG2    = 6;
  localparam int SETTLE_TICKS = 4;
  localparam int STEP         = 16;
  localparam int NSTEPS       = 64;
  localparam int PERIOD       = 10;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  audio_route_sequencer_if rt ();

  audio_route_sequencer #(
    .FADE_LOG2   (FADE_LOG2),
    .SETTLE_TICKS(SETTLE_TICKS)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .rt   (rt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Packed as {reverb, filter, crush, distortion, delay, output}.
  function automatic logic [17:0] mk(input int o, input int dl, input int ds,
                                     input int cr, input int fi, input int rv);
    return {3'(rv), 3'(fi), 3'(cr), 3'(ds), 3'(dl), 3'(o)};
  endfunction

  function automatic logic [17:0] routing_now();
    return {rt.reverb_src_on_clk, rt.filter_src_on_clk, rt.crush_src_on_clk,
            rt.distortion_src_on_clk, rt.delay_src_on_clk, rt.output_src_on_clk};
  endfunction

  task automatic set_req(input logic [17:0] v);
    rt.output_src_req     = v[2:0];
    rt.delay_src_req      = v[5:3];
    rt.distortion_src_req = v[8:6];
    rt.crush_src_req      = v[11:9];
    rt.filter_src_req     = v[14:12];
    rt.reverb_src_req     = v[17:15];
  endtask

  // Called just after a falling edge; drives one rising edge and returns at the next falling edge.
  task automatic cyc(input logic t);
    rt.sample_tick = t;
    @(negedge clk);
    rt.sample_tick = 1'b0;
  endtask

  task automatic tick_after(input int lead);
    repeat (lead) cyc(1'b0);
    cyc(1'b1);
  endtask

  task automatic fade_out(input logic [17:0] old_v, input logic [17:0] new_v, input int lead,
                          input bit change, input logic [17:0] nreq);
    for (int k = 1; k <= NSTEPS; k++) begin
      tick_after((k == 1) ? lead : PERIOD - 1);
      check("fade_out_gain", 32'(rt.fade_gain), 32'(1024 - k * STEP));
      if (change && k == 10) set_req(nreq);
      if (k == NSTEPS - 1) check("route_hold", 32'(routing_now()), 32'(old_v));
      if (k == NSTEPS) begin
        check("route_swap", 32'(routing_now()), 32'(new_v));
        check("busy_in_settle", 32'(rt.busy), 32'd1);
      end
    end
  endtask

  task automatic settle();
    for (int k = 1; k <= SETTLE_TICKS; k++) begin
      tick_after(PERIOD - 1);
      check("settle_gain", 32'(rt.fade_gain), 32'd0);
    end
  endtask

  task automatic fade_in(input int n);
    for (int k = 1; k <= n; k++) begin
      tick_after(PERIOD - 1);
      check("fade_in_gain", 32'(rt.fade_gain), 32'(k * STEP));
      if (k < NSTEPS) check("busy_fade_in", 32'(rt.busy), 32'd1);
    end
    if (n == NSTEPS) begin
      check("busy_done", 32'(rt.busy), 32'd0);
      check("err_cleared", 32'(rt.cfg_error), 32'd0);
    end
  endtask

  task automatic full_seq(input logic [17:0] old_v, input logic [17:0] new_v,
                          input bit change, input logic [17:0] nreq);
    set_req(new_v);
    fade_out(old_v, new_v, PERIOD - 1, change, nreq);
    settle();
    fade_in(NSTEPS);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [17:0] va, vb, vc, vl, vz, ve, bad, act;
    va  = mk(4, 0, 0, 0, 0, 0);
    vb  = mk(3, 0, 0, 0, 0, 0);
    vc  = mk(5, 0, 0, 0, 0, 0);
    vl  = mk(1, 2, 1, 0, 0, 0);
    vz  = '0;
    ve  = mk(2, 0, 0, 0, 0, 0);
    set_req(vz);
    rt.sample_tick = 1'b0;

    repeat (2) @(negedge clk);
    check("rst_gain",  32'(rt.fade_gain), 32'd1024);
    check("rst_busy",  32'(rt.busy), 32'd0);
    check("rst_err",   32'(rt.cfg_error), 32'd0);
    check("rst_route", 32'(routing_now()), 32'd0);
    rst_n = 1'b1;

    // Basic swap to output <- filter.
    full_seq(vz, va, 1'b0, vz);
    tick_after(3);
    tick_after(3);
    check("idle_same_busy", 32'(rt.busy), 32'd0);
    check("idle_same_gain", 32'(rt.fade_gain), 32'd1024);

    // Reserved code: rejected immediately, held request does not retrigger.
    bad = mk(4, 0, 0, 0, 7, 0);
    set_req(bad);
    cyc(1'b0);
    check("reserved_err",   32'(rt.cfg_error), 32'd1);
    check("reserved_busy",  32'(rt.busy), 32'd0);
    check("reserved_route", 32'(routing_now()), 32'(va));
    repeat (3) tick_after(PERIOD - 1);
    check("reserved_hold_busy",  32'(rt.busy), 32'd0);
    check("reserved_hold_gain",  32'(rt.fade_gain), 32'd1024);
    check("reserved_hold_route", 32'(routing_now()), 32'(va));

    // Self-referencing stage (delay fed by delay).
    set_req(mk(4, 1, 0, 0, 0, 0));
    cyc(1'b0);
    check("self_err",  32'(rt.cfg_error), 32'd1);
    check("self_busy", 32'(rt.busy), 32'd0);

    // Request changed mid fade-out: first completes, then the newer one runs.
    full_seq(va, vb, 1'b1, vc);
    check("mid_change_route", 32'(routing_now()), 32'(vb));
    full_seq(vb, vc, 1'b0, vz);

    // Loop output->delay->distortion->delay.
`ifdef ROUTE_LOOP_CHECK_EN
    set_req(vl);
    cyc(1'b0);
    check("loop_busy_start", 32'(rt.busy), 32'd1);
    repeat (7) cyc(1'b0);
    check("loop_busy_end", 32'(rt.busy), 32'd0);
    check("loop_err",      32'(rt.cfg_error), 32'd1);
    check("loop_route",    32'(routing_now()), 32'(vc));
    tick_after(PERIOD - 1);
    check("loop_hold_busy", 32'(rt.busy), 32'd0);
    check("loop_hold_gain", 32'(rt.fade_gain), 32'd1024);
    act = vc;
`else
    full_seq(vc, vl, 1'b0, vz);
    check("loop_applied", 32'(routing_now()), 32'(vl));
    act = vl;
`endif

    // Tick on the same edge the fade starts is counted.
    set_req(vz);
`ifdef ROUTE_LOOP_CHECK_EN
    fade_out(act, vz, 1, 1'b0, vz);
`else
    fade_out(act, vz, 0, 1'b0, vz);
`endif
    settle();
    fade_in(NSTEPS);

    // Reset during fade-in at half gain.
    set_req(ve);
    fade_out(vz, ve, PERIOD - 1, 1'b0, vz);
    settle();
    fade_in(NSTEPS / 2);
    check("half_gain", 32'(rt.fade_gain), 32'd512);
    rst_n = 1'b0;
    #1;
    check("async_rst_gain",  32'(rt.fade_gain), 32'd1024);
    check("async_rst_busy",  32'(rt.busy), 32'd0);
    check("async_rst_route", 32'(routing_now()), 32'd0);
    check("async_rst_err",   32'(rt.cfg_error), 32'd0);
    set_req(vz);
    @(negedge clk);
    rst_n = 1'b1;
    tick_after(3);
    check("post_rst_busy", 32'(rt.busy), 32'd0);
    check("post_rst_gain", 32'(rt.fade_gain), 32'd1024);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/audio_route_sequencer.md
AUDIO_ROUTE_SEQUENCER -- requirements
Module: audio_route_sequencer

Interface
REQ-001 Parameter FADE_LOG2, default 6: fade length is 2^FADE_LOG2 sample ticks; step = 1024 >> FADE_LOG2.
REQ-002 Parameter SETTLE_TICKS, default 4: sample ticks held at zero gain after a swap, to flush effect pipelines.
REQ-003 Port clk  input  1  sole clock; all logic on its rising edge.
REQ-004 Port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 Ports output_src_req, delay_src_req, distortion_src_req, crush_src_req, filter_src_req, reverb_src_req  input  3 each  requested routing source per stage.
REQ-006 Port sample_tick  input  1  one-cycle pulse per output-rate sample (the mux valid_to_output strobe).
REQ-007 Ports output_src_on_clk, delay_src_on_clk, distortion_src_on_clk, crush_src_on_clk, filter_src_on_clk, reverb_src_on_clk  output  3 each  registered active routing, driving the audio multiplexer.
REQ-008 Port fade_gain  output  11  registered output gain; 1024 = unity, 0 = mute.
REQ-009 Port busy  output  1  high whenever the FSM is not in IDLE.
REQ-010 Port cfg_error  output  1  sticky flag: the last candidate configuration was rejected.

Function
REQ-011 Source encoding: 0 base, 1 delay, 2 distortion, 3 crush, 4 filter, 5 reverb; codes 6 and 7 are reserved.
REQ-012 The FSM states are IDLE, CHECK, FADE_OUT, SETTLE, FADE_IN.
REQ-013 IDLE: when the request vector differs from both the active vector and the rejected snapshot, it is latched as the candidate and the FSM leaves IDLE on the next clock.
REQ-014 A candidate containing any reserved code, or any stage naming itself as its source, is rejected in IDLE: the rejected snapshot is updated, cfg_error is set, the FSM stays in IDLE, and the active routing is unchanged.
REQ-015 CHECK walks the candidate from output_src, one hop per clock, to at most 6 hops; reaching 0 means FADE_OUT; otherwise the candidate is rejected (same actions as REQ-014) and the FSM returns to IDLE.
REQ-016 A candidate of output_src = 0 passes CHECK after 1 clock.
REQ-017 FADE_OUT: on each sample_tick, fade_gain decreases by one step; the tick that makes it 0 moves the FSM to SETTLE.
REQ-018 On the clock entering SETTLE, all six *_src_on_clk outputs load the candidate simultaneously; they change at no other time except reset.
REQ-019 SETTLE: counts SETTLE_TICKS sample_ticks with fade_gain = 0, then moves to FADE_IN.
REQ-020 FADE_IN: on each sample_tick, fade_gain increases by one step; reaching 1024 moves the FSM to IDLE and clears cfg_error.
REQ-021 fade_gain saturates in [0, 1024] and never wraps.
REQ-022 sample_tick is ignored in IDLE and CHECK.
REQ-023 A tick on the same clock as state entry counts toward the new state.
REQ-024 Request changes while busy are ignored.
REQ-025 On return to IDLE, the request is re-evaluated per REQ-013, so the latest request wins.
REQ-026 A request equal to the active vector never starts a sequence, even if it differs from the rejected snapshot.

Reset
REQ-027 While rst_n = 0 (asynchronous): FSM = IDLE, all *_src_on_clk = 0, fade_gain = 1024, busy = 0, cfg_error = 0.
REQ-028 While rst_n = 0 (asynchronous): candidate, rejected snapshot and counters = 0.
REQ-029 Reset asserted mid-fade restores unity gain and the base routing immediately, with no fade.

Configuration
REQ-030 Macro ROUTE_LOOP_CHECK_EN defined: CHECK exists and behaves per REQ-015.
REQ-031 Macro ROUTE_LOOP_CHECK_EN undefined: CHECK is omitted, IDLE goes directly to FADE_OUT, and only the REQ-014 checks raise cfg_error.

Verification
REQ-032 After reset, request output=4, reverb=0, others 0, with ticks every 10 clocks -> gain falls 1024,1008,...,0 over 64 ticks, outputs swap on SETTLE entry, 4 ticks at 0, ramp back to 1024, busy low.
REQ-033 Request output=1, delay=2, distortion=1 (loop) -> cfg_error=1, routing unchanged, busy drops within 8 clocks; with the macro off the loop is applied.
REQ-034 Request filter_src=7 -> immediate cfg_error=1, no fade, and the same request held does not retrigger.
REQ-035 Change the request mid FADE_OUT -> first candidate completes, then a second full sequence applies the newer request.
REQ-036 Assert rst_n=0 at gain 512 during FADE_IN -> gain 1024, all src 0, busy 0 asynchronously, before the next clock edge.
REQ-037 Tick coincident with CHECK->FADE_OUT transition -> counted; gain 1008 on that edge.
